// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI byte engine.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    BYTE_END,
    DONE
  } spi_state_e;

  localparam logic       SPI_OP_WRITE = 1'b1;
  localparam logic       SPI_OP_READ  = 1'b0;
  localparam logic [7:0] SD_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/sd_spi_clkgen.sv
// SCLK divider: toggles sclk every CLK_DIV clk cycles while enabled and
// flags the clk cycle in which each rising/falling SCLK edge is launched.
module sd_spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick      = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = tick && !sclk;
  assign fall_tick = tick && sclk;

  // Disabling forces sclk low so the line idles low between bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sd_spi_engine.sv
// Mode-0 SPI master executing byte bursts for the SD command controller;
// read bursts skip the card's 0xFF fill and land response bytes in a buffer.
module sd_spi_engine
  import sd_spi_pkg::*;
#(
  parameter int MEMORY_SIZE_IN_BYTES = 64,
  parameter int CLK_DIV              = 4,
  parameter int NCR_MAX              = 8,
  localparam int AW                  = $clog2(MEMORY_SIZE_IN_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          op,
  input  logic [AW-1:0] size,
  input  logic [7:0]    data_in,
  output logic [AW-1:0] address,
  output logic [7:0]    data_out,
  output logic          done,
  output logic          timeout,
  input  logic          ss,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          sclk,
  output logic          mosi,
  input  logic          miso,
  output logic          cs_n
);

  localparam int NW = $clog2(NCR_MAX + 1);

  spi_state_e    state_q, state_d;
  logic          op_q, hunting_q;
  logic [AW-1:0] size_q, idx_q;
  logic [NW-1:0] ncr_q;
  logic [6:0]    tx_q;
  logic [7:0]    rx_q, load_byte;
  logic [2:0]    bit_q;
  logic          rise_tick, fall_tick, shift_en;
  logic          keep_hunting, ncr_hit, at_end, finish, buf_we, idx_inc;
  logic [7:0]    mem [MEMORY_SIZE_IN_BYTES];

  assign shift_en = (state_q == SHIFT);

  sd_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (shift_en),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign load_byte    = (op_q == SPI_OP_WRITE) ? data_in : SD_IDLE_BYTE;
  assign keep_hunting = hunting_q && (rx_q == SD_IDLE_BYTE);
  assign ncr_hit      = keep_hunting && (ncr_q == NW'(NCR_MAX - 1));
  assign at_end       = (idx_q == size_q);
  assign finish       = keep_hunting ? ncr_hit : at_end;
  // While hunting idx_q is still 0, so a timeout writes the 0xFF rx into slot 0.
  assign buf_we  = (state_q == BYTE_END) && (op_q == SPI_OP_READ) && (!keep_hunting || ncr_hit);
  assign idx_inc = (state_q == BYTE_END) && !keep_hunting && !at_end;

  assign done    = (state_q == DONE);
  assign address = (state_q != IDLE && op_q == SPI_OP_WRITE) ? idx_q : '0;
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (start) state_d = LOAD;
      LOAD:     state_d = SHIFT;
      SHIFT:    if (fall_tick && bit_q == 3'd0) state_d = BYTE_END;
      BYTE_END: state_d = finish ? DONE : LOAD;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= SPI_OP_READ;
      hunting_q <= 1'b0;
      size_q    <= '0;
      idx_q     <= '0;
      ncr_q     <= '0;
      tx_q      <= '1;
      rx_q      <= SD_IDLE_BYTE;
      bit_q     <= '0;
      mosi      <= 1'b1;
      data_out  <= SD_IDLE_BYTE;
      timeout   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          mosi <= 1'b1;
          if (start) begin
            op_q      <= op;
            size_q    <= size;
            idx_q     <= '0;
            ncr_q     <= '0;
            hunting_q <= (op == SPI_OP_READ);
            timeout   <= 1'b0;
          end
        end
        LOAD: begin
          mosi  <= load_byte[7];
          tx_q  <= load_byte[6:0];
          bit_q <= 3'd7;
        end
        SHIFT: begin
          if (rise_tick) rx_q <= {rx_q[6:0], miso};
          if (fall_tick && bit_q != 3'd0) begin
            bit_q <= bit_q - 3'd1;
            mosi  <= tx_q[6];
            tx_q  <= {tx_q[5:0], 1'b1};
          end
        end
        BYTE_END: begin
          data_out <= rx_q;
          mosi     <= 1'b1;
          if (keep_hunting) ncr_q <= ncr_q + 1'b1;
          else              hunting_q <= 1'b0;
          if (ncr_hit) timeout <= 1'b1;
          if (idx_inc) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cs_n <= 1'b1;
    else        cs_n <= ss;
  end

  always_ff @(posedge clk) begin
    if (buf_we) mem[idx_q] <= rx_q;
  end

endmodule
